seq_magnitude_comparator: RTL and testbench

//  Multi-cycle signed/unsigned magnitude comparator. Successor to the combinational less-than comparator.

---
 rtl/seq_magnitude_comparator.sv | 197 +++++++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle signed/unsigned magnitude comparator. Operands are compared
// CHUNK bits per cycle, most significant chunk first, stopping at the first
// chunk that differs. Results are registered and presented under a
// start/busy/done handshake.
//
// Parameters
//   WIDTH      operand width in bits (multiple of CHUNK)
//   CHUNK      bits compared per cycle; NCHUNK = WIDTH/CHUNK
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high; aborts any compare in flight
//   start      request a compare; sampled only when not busy
//   is_signed  1 = two's-complement compare, 0 = unsigned (latched on start)
//   A, B       operands, latched on an accepted start
//   busy       high while comparing
//   done       one-cycle pulse, results valid from this cycle
//   A_lt_B     registered A <  B
//   A_eq_B     registered A == B
//   A_gt_B     registered A >  B
//   min_out    smaller operand (only with CMP_MINMAX_EN, else constant 0)
//   max_out    larger operand  (only with CMP_MINMAX_EN, else constant 0)
//
// Build option
//   CMP_MINMAX_EN  when defined, min_out/max_out are registered on completion;
//                  when undefined they are tied to zero and no WIDTH-wide
//                  result registers exist.
// ---------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             A_gt_B,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic [IDXW-1:0]  idx_q;
  logic             lt_q, eq_q, gt_q;

  logic             accept;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] a_ord, b_ord;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_lt, chunk_gt;
  logic             last_chunk;
  logic             finish;

  // A new compare is taken in IDLE or DONE only; start is ignored in CMP.
  assign accept = (state_q != S_CMP) && start;

  // Chunk datapath. In signed mode the operand MSB is inverted, which maps
  // two's-complement order onto unsigned order. Only the top chunk holds
  // that bit, so flipping the whole vector before slicing is equivalent.
  always_comb begin
    flip            = '0;
    flip[WIDTH-1]   = signed_q;
    a_ord           = a_q ^ flip;
    b_ord           = b_q ^ flip;
    a_chunk         = a_ord[int'(idx_q) * CHUNK +: CHUNK];
    b_chunk         = b_ord[int'(idx_q) * CHUNK +: CHUNK];
    chunk_lt        = (a_chunk < b_chunk);
    chunk_gt        = (a_chunk > b_chunk);
    last_chunk      = (idx_q == '0);
    finish          = chunk_lt || chunk_gt || last_chunk;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = start ? S_CMP : S_IDLE;
      end
      S_CMP: begin
        state_d = finish ? S_DONE : S_CMP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy   = (state_q == S_CMP);
    done   = (state_q == S_DONE);
    A_lt_B = lt_q;
    A_eq_B = eq_q;
    A_gt_B = gt_q;
  end

  // ---------------------------------------------------------------------
  // Operand capture, chunk index and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      signed_q <= is_signed;
      idx_q    <= IDX_TOP;
    end else if (state_q == S_CMP) begin
      if (chunk_lt || chunk_gt) begin
        lt_q <= chunk_lt;
        eq_q <= 1'b0;
        gt_q <= chunk_gt;
      end else if (last_chunk) begin
        lt_q <= 1'b0;
        eq_q <= 1'b1;
        gt_q <= 1'b0;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] min_q, max_q;

  // The deciding chunk's order is the overall order, so the terminal
  // chunk result selects min/max directly; equal operands report A twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_q <= '0;
      max_q <= '0;
    end else if ((state_q == S_CMP) && finish) begin
      if (chunk_lt) begin
        min_q <= a_q;
        max_q <= b_q;
      end else if (chunk_gt) begin
        min_q <= b_q;
        max_q <= a_q;
      end else begin
        min_q <= a_q;
        max_q <= a_q;
      end
    end
  end

  assign min_out = min_q;
  assign max_out = max_q;
`else
  assign min_out = '0;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int LIMIT  = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A, B;
  logic             busy, done;
  logic             A_lt_B, A_eq_B, A_gt_B;
  logic [WIDTH-1:0] min_out, max_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]         res;   // {lt, eq, gt}
    int                 lat;   // cycle (start cycle = 0) in which done is seen
    logic [2*WIDTH-1:0] mm;    // {min, max}
  } exp_t;

  exp_t sb[$];

  seq_magnitude_comparator #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .A_lt_B    (A_lt_B),
    .A_eq_B    (A_eq_B),
    .A_gt_B    (A_gt_B),
    .min_out   (min_out),
    .max_out   (max_out)
  );

  always #5 clk = ~clk;

  // Reference: ordering from native signed/unsigned compare; chunks examined
  // from the highest differing bit of A^B (the signed MSB flip cancels in XOR).
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t e;
    logic lt, gt, eq;
    logic [WIDTH-1:0] d;
    int p;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    gt = s ? ($signed(a) > $signed(b)) : (a > b);
    eq = (a == b);
    e.res = {lt, eq, gt};
    d = a ^ b;
    p = -1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i]) begin
        p = i;
        break;
      end
    end
    e.lat = (p < 0) ? (NCHUNK + 1) : (NCHUNK - p / CHUNK + 1);
`ifdef CMP_MINMAX_EN
    if (lt)      e.mm = {a, b};
    else if (gt) e.mm = {b, a};
    else         e.mm = {a, a};
`else
    e.mm = '0;
`endif
    return e;
  endfunction

  // Called at a negedge; accepting edge is the next posedge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    A         = a;
    B         = b;
    is_signed = s;
    start     = 1'b1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Bounded wait for done; lat is the cycle number it was seen in.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (!done && lat <= LIMIT) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, A_lt_B, A_eq_B, A_gt_B} !== 5'b0 || {min_out, max_out} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy/done/lt/eq/gt=%b min=%h max=%h want all zero",
               {busy, done, A_lt_B, A_eq_B, A_gt_B}, min_out, max_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta[7] = '{32'd0, 32'd0, 32'd52315, 32'd521252, 32'd521253,
                                32'h7FFFFFFF, 32'h7FFFFFFF};
    logic [WIDTH-1:0] tb_[7] = '{32'd0, 32'd51, 32'd0, 32'd521253, 32'd521253,
                                 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic ts[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bn;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb_[i], ts[i]);
      wait_done(lat, bn);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, e.lat);
      end
      checks++;
      if ({A_lt_B, A_eq_B, A_gt_B} !== e.res) begin
        failures++;
        $display("FAIL dir%0d_result got lt/eq/gt=%b want %b", i, {A_lt_B, A_eq_B, A_gt_B}, e.res);
      end
      checks++;
      if ({min_out, max_out} !== e.mm) begin
        failures++;
        $display("FAIL dir%0d_minmax got %h want %h", i, {min_out, max_out}, e.mm);
      end
      if (i == 0) begin
        checks++;
        if (bn !== NCHUNK) begin
          failures++;
          $display("FAIL dir0_busy_cycles got %0d want %0d", bn, NCHUNK);
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_done_pulse got done=%b one cycle later want 0", i, done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, bn;
    exp_t e;
    issue(32'd521253, 32'd521253, 1'b0);   // now in cycle +1, DUT busy
    A     = 32'd5;
    B     = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bn);
    lat = lat + 1;                          // one cycle spent pulsing start
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL ignore_latency got %0d want %0d", lat, e.lat);
    end
    checks++;
    if ({A_lt_B, A_eq_B, A_gt_B} !== e.res) begin
      failures++;
      $display("FAIL ignore_result got lt/eq/gt=%b want %b", {A_lt_B, A_eq_B, A_gt_B}, e.res);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || {A_lt_B, A_eq_B, A_gt_B} !== e.res) begin
      failures++;
      $display("FAIL ignore_hold got busy/done=%b lt/eq/gt=%b want 00 %b",
               {busy, done}, {A_lt_B, A_eq_B, A_gt_B}, e.res);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    exp_t e;
    issue(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(lat, bn);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || {A_lt_B, A_eq_B, A_gt_B} !== e.res) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d res=%b want lat=%0d res=%b",
               lat, {A_lt_B, A_eq_B, A_gt_B}, e.lat, e.res);
    end
    issue(32'd5, 32'd9, 1'b0);               // start asserted in the DONE cycle
    wait_done(lat, bn);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL b2b_latency got %0d want %0d", lat, e.lat);
    end
    checks++;
    if ({A_lt_B, A_eq_B, A_gt_B} !== e.res || {min_out, max_out} !== e.mm) begin
      failures++;
      $display("FAIL b2b_result got res=%b mm=%h want res=%b mm=%h",
               {A_lt_B, A_eq_B, A_gt_B}, {min_out, max_out}, e.res, e.mm);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int seen;
    issue(32'd521253, 32'd521253, 1'b0);     // cycle +1
    void'(sb.pop_front());                   // this compare never completes
    @(negedge clk);                          // cycle +2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, A_lt_B, A_eq_B, A_gt_B} !== 5'b0 || {min_out, max_out} !== '0) begin
      failures++;
      $display("FAIL abort_state got busy/done/lt/eq/gt=%b min=%h max=%h want all zero",
               {busy, done, A_lt_B, A_eq_B, A_gt_B}, min_out, max_out);
    end
    seen = 0;
    repeat (2 * NCHUNK + 4) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done got %0d busy/done cycles want 0", seen);
    end
  endtask

  task automatic test_random();
    int lat, bn;
    exp_t e;
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, WIDTH - 1));
        2:       b = {a[WIDTH-1:CHUNK], 8'($urandom)};
        default: b = $urandom;
      endcase
      issue(a, b, 1'($urandom_range(0, 1)));
      wait_done(lat, bn);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || {A_lt_B, A_eq_B, A_gt_B} !== e.res || {min_out, max_out} !== e.mm) begin
        failures++;
        $display("FAIL rand%0d A=%h B=%h s=%b got lat=%0d res=%b mm=%h want lat=%0d res=%b mm=%h",
                 i, a, b, is_signed, lat, {A_lt_B, A_eq_B, A_gt_B}, {min_out, max_out},
                 e.lat, e.res, e.mm);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    A         = '0;
    B         = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
